// File: rtl/vert_cpld_pkg.sv
// Shared constants and types for the UART command path feeding the per-axis step generators.
package vert_cpld_pkg;

  localparam int unsigned NUM_AXES            = 10;
  localparam int unsigned DIV_W               = 15;
  localparam int unsigned STEP_W              = 13;
  localparam int unsigned FRAME_BYTES         = 5;
  localparam int unsigned PAYLOAD_BYTES       = FRAME_BYTES - 1;
  localparam int unsigned AXIS_W              = 4;
  localparam int unsigned DROP_W              = 8;
  localparam int unsigned DIV_LSB             = 4;
  localparam int unsigned STEP_LSB            = 19;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 24000;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } parserState_e;

  // Decoded command word W[31:4]; steps occupy the upper field.
  typedef struct packed {
    logic [STEP_W-1:0] steps;
    logic [DIV_W-1:0]  divider;
  } axisCmd_t;

endpackage

// File: rtl/axis_cmd_slot.sv
// One axis's command registers: divider, step count and pending flag, released by the motor's
// activeMode rising edge.
module axis_cmd_slot
  import vert_cpld_pkg::*;
(
  input  logic              CLK_SE_AR,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [STEP_W-1:0] wr_steps,
  input  logic              axis_active,
  output logic [DIV_W-1:0]  divider,
  output logic [STEP_W-1:0] steps,
  output logic              pending,
  output logic              eff_pending_c
);

  logic activeQ;
  logic actRise;

  assign actRise       = axis_active & ~activeQ;
  assign eff_pending_c = pending & ~actRise;

  // A write in the same cycle as a release wins, so the new command stays pending.
  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      activeQ <= 1'b0;
      divider <= '0;
      steps   <= '0;
      pending <= 1'b0;
    end else begin
      activeQ <= axis_active;
      if (wr_en) begin
        divider <= wr_div;
        steps   <= wr_steps;
        pending <= 1'b1;
      end else if (actRise) begin
        steps   <= '0;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte UART frames (header + little-endian 32-bit word) into per-axis divider and
// step-count commands, with frame timeout, bad-index reporting and busy-drop counting.
module uart_cmd_parser
  import vert_cpld_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       CLK_SE_AR,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic [NUM_AXES-1:0]        axis_active,
  output logic [NUM_AXES*DIV_W-1:0]  divider,
  output logic [NUM_AXES*STEP_W-1:0] steps_to_go,
  output logic [NUM_AXES-1:0]        pending,
  output logic [NUM_AXES-1:0]        load_strb,
  output logic                       frame_err,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W  = $clog2(PAYLOAD_BYTES);
  localparam int unsigned KEEP_W = DIV_W + STEP_W - 8;

  parserState_e              state;
  parserState_e              stateNext;
  logic                      rxValidQ;
  logic                      byteEv;
  logic [AXIS_W-1:0]         axisQ;
  logic [CNT_W-1:0]          cnt;
  logic [KEEP_W-1:0]         wReg;
  logic [TO_W-1:0]           toCnt;
  logic                      toHit;
  logic                      lastByte;
  logic                      commit;
  logic                      timeoutAbort;
  logic                      axisBad;
  logic                      busyHit;
  logic [NUM_AXES-1:0]       wrEn;
  logic [NUM_AXES-1:0]       effPending;
  axisCmd_t                  cmdNew;

  assign byteEv   = rx_valid & ~rxValidQ;
  assign toHit    = (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign lastByte = (cnt == CNT_W'(PAYLOAD_BYTES - 1));
  // Only W[31:4] is kept: W[3:0] shifts out of wReg before the final byte arrives.
  assign cmdNew   = axisCmd_t'({rx_data, wReg});
  assign axisBad  = ({1'b0, axisQ} >= (AXIS_W + 1)'(NUM_AXES));

  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (byteEv) stateNext = PAYLOAD;
      end
      PAYLOAD: begin
        if (byteEv) begin
          if (lastByte) stateNext = IDLE;
        end else if (toHit) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    commit       = 1'b0;
    timeoutAbort = 1'b0;
    case (state)
      PAYLOAD: begin
        commit       = byteEv & lastByte;
        timeoutAbort = ~byteEv & toHit;
      end
      default: ;
    endcase
  end

  // Edge register, header latch, payload shift and frame timeout counter.
  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      rxValidQ <= 1'b0;
      axisQ    <= '0;
      cnt      <= '0;
      wReg     <= '0;
      toCnt    <= '0;
    end else begin
      rxValidQ <= rx_valid;
      if (state == IDLE) begin
        toCnt <= '0;
        if (byteEv) begin
          axisQ <= rx_data[AXIS_W-1:0];
          cnt   <= '0;
        end
      end else if (byteEv) begin
        wReg  <= {rx_data, wReg[KEEP_W-1:8]};
        cnt   <= cnt + CNT_W'(1);
        toCnt <= '0;
      end else if (!toHit) begin
        toCnt <= toCnt + TO_W'(1);
      end
    end
  end

  always_comb begin
    busyHit = 1'b0;
    wrEn    = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (axisQ == AXIS_W'(i)) begin
        busyHit = effPending[i];
        wrEn[i] = commit & ~effPending[i];
      end
    end
  end

  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      load_strb <= '0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      load_strb <= wrEn;
      frame_err <= (commit & axisBad) | timeoutAbort;
      if (commit && !axisBad && busyHit && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_AXES; i++) begin : gSlot
    axis_cmd_slot uSlot (
      .CLK_SE_AR     (CLK_SE_AR),
      .rst           (rst),
      .wr_en         (wrEn[i]),
      .wr_div        (cmdNew.divider),
      .wr_steps      (cmdNew.steps),
      .axis_active   (axis_active[i]),
      .divider       (divider[i*DIV_W +: DIV_W]),
      .steps         (steps_to_go[i*STEP_W +: STEP_W]),
      .pending       (pending[i]),
      .eff_pending_c (effPending[i])
    );
  end

endmodule
